// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants and round-controller state encoding
package sha256_pkg;

    localparam int ROUND_IDX_W     = 6;
    localparam int NUM_ROUNDS_DEF  = 64;
    localparam int SCHED_START_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // DONE is deliberately not busy: the digest is already valid in H.
    function automatic logic state_is_busy(input state_e s);
        return (s == ST_INIT) || (s == ST_ROUND) || (s == ST_FINAL);
    endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// rtl/sha256_round_ctrl_if.sv - command and datapath-control signals of the round controller
interface sha256_round_ctrl_if;
    import sha256_pkg::*;

    logic                   start;
    logic                   first_block;
    logic                   abort;
    logic                   busy;
    logic                   init_wv;
    logic                   init_h;
    logic                   round_en;
    logic [ROUND_IDX_W-1:0] round_idx;
    logic                   w_sel_sched;
    logic                   sched_en;
    logic                   final_add;
    logic                   done;

    modport master (
        output start, first_block, abort,
        input  busy, init_wv, init_h, round_en, round_idx,
        input  w_sel_sched, sched_en, final_add, done
    );

    modport slave (
        input  start, first_block, abort,
        output busy, init_wv, init_h, round_en, round_idx,
        output w_sel_sched, sched_en, final_add, done
    );

endinterface

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - block sequencer: INIT, NUM_ROUNDS rounds, FINAL add, DONE pulse
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int SCHED_START = SCHED_START_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    sha256_round_ctrl_if.slave  bus
);

    localparam logic [ROUND_IDX_W-1:0] LAST_IDX  = ROUND_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_IDX_W:0]   SCHED_IDX = (ROUND_IDX_W + 1)'(SCHED_START);

    state_e                 state_q, state_d;
    logic [ROUND_IDX_W-1:0] idx_q, idx_d;
    logic                   fb_q, fb_d;

    logic busy_q;
    logic init_wv_q;
    logic init_h_q;
    logic round_en_q;
    logic w_sel_q;
    logic final_q;
    logic done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fb_d    = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_INIT;
                    fb_d    = bus.first_block;
                end
            end
            ST_INIT:  state_d = ST_ROUND;
            ST_ROUND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINAL;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        // Abort outranks every other transition, FINAL->DONE included.
        if (bus.abort && state_is_busy(state_q)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            fb_q       <= 1'b0;
            busy_q     <= 1'b0;
            init_wv_q  <= 1'b0;
            init_h_q   <= 1'b0;
            round_en_q <= 1'b0;
            w_sel_q    <= 1'b0;
            final_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fb_q       <= fb_d;
            busy_q     <= state_is_busy(state_d);
            init_wv_q  <= (state_d == ST_INIT);
            init_h_q   <= (state_d == ST_INIT) && fb_d;
            round_en_q <= (state_d == ST_ROUND);
            w_sel_q    <= (state_d == ST_ROUND) && ({1'b0, idx_d} >= SCHED_IDX);
            final_q    <= (state_d == ST_FINAL);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.init_wv     = init_wv_q;
    assign bus.init_h      = init_h_q;
    assign bus.round_en    = round_en_q;
    assign bus.round_idx   = idx_q;
    assign bus.w_sel_sched = w_sel_q;
    assign bus.sched_en    = round_en_q;
    assign bus.final_add   = final_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - scoreboard bench for the SHA-256 round controller
module tb_sha256_round_ctrl;

    localparam int NR  = 64;
    localparam int SCH = 16;

    typedef struct {
        int   cyc;
        int   kind;   // 0 init, 1 round, 2 final, 3 done
        int   idx;
        logic fb;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_until;
    int   cur_a;
    ev_t  q[$];

    sha256_round_ctrl_if u_if ();

    sha256_round_ctrl #(.NUM_ROUNDS(NR), .SCHED_START(SCH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] exp_vec(input ev_t e);
        logic       rnd;
        logic [5:0] idx;
        rnd = (e.kind == 1);
        idx = rnd ? 6'(e.idx) : 6'd0;
        return {e.kind != 3, e.kind == 0, (e.kind == 0) && e.fb, rnd, idx,
                rnd && (e.idx >= SCH), rnd, e.kind == 2, e.kind == 3};
    endfunction

    function automatic logic [13:0] act_vec();
        return {u_if.busy, u_if.init_wv, u_if.init_h, u_if.round_en, u_if.round_idx,
                u_if.w_sel_sched, u_if.sched_en, u_if.final_add, u_if.done};
    endfunction

    // Monitor: one comparison per cycle against the scheduled event, or all-zero when idle.
    always @(negedge clk) begin : monitor
        logic [13:0] act;
        logic [13:0] expv;
        ev_t         e;
        act  = act_vec();
        expv = '0;
        if (rst_n && q.size() > 0 && q[0].cyc == cyc) begin
            e    = q.pop_front();
            expv = exp_vec(e);
        end
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, expv);
        end
    end

    // Reference model: a block accepted at edge a occupies INIT a, rounds a+1..a+64,
    // FINAL a+65, DONE a+66; abort in a..a+65 drops everything after the current cycle.
    task automatic drive(input logic s, input logic fb, input logic ab);
        int k;
        k = cyc;
        u_if.start       = s;
        u_if.first_block = fb;
        u_if.abort       = ab;
        if (rst_n) begin
            if (ab && k >= cur_a && k <= cur_a + NR + 1) begin
                while (q.size() > 0 && q[$].cyc > k) void'(q.pop_back());
                busy_until = k;
                cur_a      = -1000;
            end
            if (s && k > busy_until) begin
                cur_a      = k + 1;
                busy_until = cur_a + NR + 2;
                q.push_back('{cur_a, 0, 0, fb});
                for (int t = 0; t < NR; t++) q.push_back('{cur_a + 1 + t, 1, t, 1'b0});
                q.push_back('{cur_a + NR + 1, 2, 0, 1'b0});
                q.push_back('{cur_a + NR + 2, 3, 0, 1'b0});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 14'd0) begin
            errors++;
            $display("FAIL reset_immediate actual=%b required=%b", act_vec(), 14'd0);
        end
        q.delete();
        cur_a = -1000;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        busy_until = cyc - 1;
    endtask

    task automatic block(input logic fb, input int off, input logic ab_at,
                         input logic st_at, input logic rst_at);
        int a;
        drive(1'b1, fb, 1'b0);
        a = cyc;
        while (cyc < a + off) drive(1'b0, 1'($urandom), 1'b0);
        if (rst_at) async_reset();
        else        drive(st_at, 1'($urandom), ab_at);
        repeat (72) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc              = 0;
        checks           = 0;
        errors           = 0;
        busy_until       = 1 << 30;
        cur_a            = -1000;
        rst_n            = 1'b0;
        u_if.start       = 1'b0;
        u_if.first_block = 1'b0;
        u_if.abort       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        busy_until = cyc - 1;

        block(1'b1, 0, 1'b0, 1'b0, 1'b0);       // full block from IV
        block(1'b0, 0, 1'b0, 1'b0, 1'b0);       // chained block
        for (int i = 0; i < 150; i++) drive(1'b1, 1'($urandom), 1'b0);
        repeat (72) drive(1'b0, 1'b0, 1'b0);
        block(1'b1, 0, 1'b1, 1'b0, 1'b0);       // abort in INIT
        block(1'b0, 31, 1'b1, 1'b0, 1'b0);      // abort at round_idx 30
        block(1'b1, NR + 1, 1'b1, 1'b0, 1'b0);  // abort in FINAL
        block(1'b0, NR + 2, 1'b1, 1'b0, 1'b0);  // abort in DONE: ignored
        block(1'b1, NR + 2, 1'b0, 1'b1, 1'b0);  // start in DONE: ignored
        block(1'b1, 51, 1'b0, 1'b0, 1'b1);      // reset at round_idx 50
        block(1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(19, 0) == 0, 1'($urandom), $urandom_range(99, 0) == 0);
        repeat (72) drive(1'b0, 1'b0, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 64, compression rounds per 512-bit block.
REQ-002 Parameter SCHED_START, default 16, first round whose W_t comes from the message schedule rather than the block words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to compress one block; sampled only in IDLE.
REQ-006 first_block  input  1  sampled with accepted start; 1 = hash chain starts from IV.
REQ-007 abort  input  1  synchronous cancel of the block in progress.
REQ-008 busy  output  1  high in INIT, ROUND and FINAL.
REQ-009 init_wv  output  1  datapath loads a..h from H (or from IV when init_h=1).
REQ-010 init_h  output  1  datapath loads H0..H7 with IV; asserted only together with init_wv.
REQ-011 round_en  output  1  datapath executes one round (Ch/Maj/Sigma update of a..h).
REQ-012 round_idx  output  6  current round t, K-ROM address; 0 outside ROUND.
REQ-013 w_sel_sched  output  1  1 when W_t comes from the schedule (round_idx >= SCHED_START and round_en=1).
REQ-014 sched_en  output  1  advance the message-schedule window; equals round_en.
REQ-015 final_add  output  1  datapath performs H_i += a..h.
REQ-016 done  output  1  single-cycle pulse: digest for this block is valid in H.

Function
REQ-017 FSM states: IDLE, INIT, ROUND, FINAL, DONE.
REQ-018 IDLE -> INIT when start=1; first_block is latched on the same edge.
REQ-019 INIT lasts exactly 1 cycle: init_wv=1, init_h=latched first_block; next state ROUND.
REQ-020 ROUND lasts exactly NUM_ROUNDS cycles: round_en=1, round_idx counts 0..NUM_ROUNDS-1, +1 per cycle.
REQ-021 ROUND -> FINAL on the cycle after round_idx = NUM_ROUNDS-1; the counter does not wrap past NUM_ROUNDS-1.
REQ-022 FINAL lasts 1 cycle: final_add=1; next state DONE.
REQ-023 DONE lasts 1 cycle: done=1, busy=0; next state IDLE unconditionally.
REQ-024 Latency: start sampled at edge N gives INIT in cycle N+1, rounds in N+2..N+65, FINAL in N+66 and done in N+67 (NUM_ROUNDS=64).
REQ-025 start in any state other than IDLE is ignored and not queued, including start in the DONE cycle.
REQ-026 abort=1 in INIT, ROUND or FINAL -> IDLE on the next edge; no final_add or done is issued for that block; round_idx returns to 0.
REQ-027 abort in IDLE or DONE has no effect.
REQ-028 abort has priority over every other transition, including FINAL -> DONE.
REQ-029 All outputs are registered or decoded from state/counter only; no combinational path from any input to any output.
REQ-030 At most one of init_wv, round_en or final_add is high in any cycle.

Reset
REQ-031 rst_n=0 forces IDLE, round_idx=0 and latched first_block=0 immediately, without waiting for clk.
REQ-032 During reset all outputs are 0.
REQ-033 Reset asserted mid-block discards the block; no done follows reset release.
REQ-034 The first start is accepted on the first rising edge after reset release.

Structure
REQ-035 Shared package sha256_pkg holds the FSM state encoding, the ROUND_IDX_W=6 constant and the NUM_ROUNDS/SCHED_START defaults; the datapath reuses the same package.
REQ-036 No sub-module is used: FSM and round counter live in one module, and the K ROM stays in the datapath, addressed by round_idx.

Verification
REQ-037 Reset, then start=1 with first_block=1 for one cycle -> init_wv=init_h=1 for 1 cycle, round_en high 64 cycles with round_idx 0..63, w_sel_sched rising at idx 16, final_add at +66, done pulse at +67.
REQ-038 Second block with first_block=0 -> init_h=0 in INIT, timing otherwise identical to REQ-037.
REQ-039 start held high continuously -> blocks start every 69 cycles (done, then IDLE, then next accept); start in the DONE cycle produces no extra INIT.
REQ-040 abort at round_idx=30 -> IDLE next cycle, round_idx=0, no final_add and no done; a following start runs a full 64 rounds.
REQ-041 rst_n dropped asynchronously mid-cycle at round_idx=50 -> outputs 0 immediately; no done after release; a new start completes normally.
REQ-042 Every cycle: assert at most one of init_wv/round_en/final_add is high, busy matches the state, and done is never high for two consecutive cycles.
